// File: rtl/csi_rx_dat_deskew_pkg.sv
// ---------------------------------------------------------------------------
// csi_rx_dat_deskew_pkg
// Shared constants, the deskew FSM state type and the sync-byte hit detector
// used by the CSI-2 RX data-lane tap calibrator.
// ---------------------------------------------------------------------------
package csi_rx_dat_deskew_pkg;

  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;
  localparam int         DPHY_TAP_BITS  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    EVAL    = 3'd4,
    FINISH  = 3'd5
  } deskew_state_t;

  // True when the sync byte appears at any bit alignment whose first bit
  // lies in the older byte (offsets 0..7 of the 16-bit window).
  function automatic logic sync_hit(input logic [7:0] prev_byte,
                                    input logic [7:0] cur_byte);
    logic [15:0] window;
    logic        hit;
    window = {prev_byte, cur_byte};
    hit    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (window[15-k -: 8] == DPHY_SYNC_BYTE) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/csi_rx_tap_window.sv
// ---------------------------------------------------------------------------
// csi_rx_tap_window
// Per-lane part of the deskew calibrator: sync-byte hit detector, saturating
// hit counter, longest-good-run tracker and window centre computation.
//
// Ports:
//   byte_clock  in   byte clock
//   reset       in   synchronous active-high reset
//   sweep_clear in   clears run/best tracking at the start of a sweep
//   load        in   LOAD cycle: clears prev_byte and the hit counter
//   measure     in   MEASURE cycle: hits are counted
//   eval        in   EVAL cycle: tap verdict folded into the tracker
//   finish      in   FINISH cycle: any open run is closed
//   tap         in   tap currently being evaluated
//   data        in   deserialised byte of this lane
//   found       out  a good window exists (open run included)
//   centre      out  centre tap of the best window (open run included)
// ---------------------------------------------------------------------------
module csi_rx_tap_window
  import csi_rx_dat_deskew_pkg::*;
#(
  parameter int TAP_BITS     = 5,
  parameter int DWELL_CYCLES = 64,
  parameter int HIT_MIN      = 4
) (
  input  logic                byte_clock,
  input  logic                reset,
  input  logic                sweep_clear,
  input  logic                load,
  input  logic                measure,
  input  logic                eval,
  input  logic                finish,
  input  logic [TAP_BITS-1:0] tap,
  input  logic [7:0]          data,
  output logic                found,
  output logic [TAP_BITS-1:0] centre
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam int LEN_W = TAP_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] HIT_THR = CNT_W'(HIT_MIN);

  logic [7:0]          prev_byte;
  logic [CNT_W-1:0]    hit_count;
  logic [TAP_BITS-1:0] run_start;
  logic [LEN_W-1:0]    run_len;
  logic [TAP_BITS-1:0] best_start;
  logic [LEN_W-1:0]    best_len;

  logic                hit;
  logic                good;
  logic                run_wins;
  logic [TAP_BITS-1:0] final_start;
  logic [LEN_W-1:0]    final_len;
  logic [TAP_BITS-1:0] half_len;

  // Hit/verdict decode and the best window as it would be with the open run closed now.
  always_comb begin
    hit      = sync_hit(prev_byte, data);
    good     = (hit_count >= HIT_THR);
    // Strictly longer only, so the earliest of equal runs is kept.
    run_wins = (run_len > best_len);
    if (run_wins) begin
      final_start = run_start;
      final_len   = run_len;
    end else begin
      final_start = best_start;
      final_len   = best_len;
    end
    found    = (final_len != LEN_W'(0));
    half_len = TAP_BITS'((final_len - LEN_W'(1)) >> 1);
    centre   = final_start + half_len;
  end

  // Byte history, hit counting and run/best tracking.
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      prev_byte  <= 8'h00;
      hit_count  <= CNT_W'(0);
      run_start  <= TAP_BITS'(0);
      run_len    <= LEN_W'(0);
      best_start <= TAP_BITS'(0);
      best_len   <= LEN_W'(0);
    end else begin
      prev_byte <= load ? 8'h00 : data;

      if (load) begin
        hit_count <= CNT_W'(0);
      end else if (measure && hit && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + CNT_W'(1);
      end

      if (sweep_clear) begin
        run_start  <= TAP_BITS'(0);
        run_len    <= LEN_W'(0);
        best_start <= TAP_BITS'(0);
        best_len   <= LEN_W'(0);
      end else if (eval && good) begin
        if (run_len == LEN_W'(0)) begin
          run_start <= tap;
        end
        run_len <= run_len + LEN_W'(1);
      end else if (eval || finish) begin
        // A bad tap or the end of the sweep closes the current run.
        if (run_wins) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
        run_len <= LEN_W'(0);
      end
    end
  end

endmodule

// File: rtl/csi_rx_dat_deskew.sv
// ---------------------------------------------------------------------------
// csi_rx_dat_deskew
// Run-time IDELAY tap calibrator for 1..4 CSI-2 RX data lanes. On start it
// sweeps one shared tap over all lanes, counts sync-byte hits per lane at
// each tap, then drives every lane with the centre of its longest good run.
//
// Ports:
//   byte_clock  in   byte clock, all registers on its rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle pulse that starts a sweep (ignored while busy)
//   deser_in    in   deserialised bytes, lane n in [8n+7:8n]
//   delay_out   out  tap for each lane, lane n in [TAP_BITS*n +: TAP_BITS]
//   busy        out  sweep in progress
//   done        out  one-cycle pulse when a sweep completes
//   locked      out  per lane: good window found in the last sweep
//   fail        out  per lane: no good tap in the last sweep
// ---------------------------------------------------------------------------
module csi_rx_dat_deskew
  import csi_rx_dat_deskew_pkg::*;
#(
  parameter int NUM_LANES     = 2,
  parameter int TAP_BITS      = DPHY_TAP_BITS,
  parameter int DEFAULT_DELAY = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_CYCLES  = 64,
  parameter int HIT_MIN       = 4
) (
  input  logic                          byte_clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [8*NUM_LANES-1:0]        deser_in,
  output logic [TAP_BITS*NUM_LANES-1:0] delay_out,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_LANES-1:0]          locked,
  output logic [NUM_LANES-1:0]          fail
);

  localparam int CYC_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [TAP_BITS-1:0] TAP_MAX     = {TAP_BITS{1'b1}};
  localparam logic [TAP_BITS-1:0] DEFAULT_TAP = TAP_BITS'(DEFAULT_DELAY);
  localparam logic [CYC_W-1:0]    SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]    DWELL_LAST  = CYC_W'(DWELL_CYCLES - 1);

  deskew_state_t       state;
  logic [TAP_BITS-1:0] tap;
  logic [TAP_BITS-1:0] tap_next;
  logic [CYC_W-1:0]    cyc;

  logic                sweep_clear;
  logic                load;
  logic                measure;
  logic                eval;
  logic                finish;
  logic [NUM_LANES-1:0] lane_found;
  logic [TAP_BITS-1:0]  lane_centre [NUM_LANES];

  // Per-lane tracker strobes decoded from the registered state.
  always_comb begin
    sweep_clear = (state == IDLE) && start;
    load        = (state == LOAD);
    measure     = (state == MEASURE);
    eval        = (state == EVAL);
    finish      = (state == FINISH);
    tap_next    = tap + TAP_BITS'(1);
  end

  // Shared sweep FSM with tap and cycle counters; all outputs registered here.
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state     <= IDLE;
      tap       <= TAP_BITS'(0);
      cyc       <= CYC_W'(0);
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= {NUM_LANES{1'b0}};
      fail      <= {NUM_LANES{1'b0}};
      delay_out <= {NUM_LANES{DEFAULT_TAP}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tap       <= TAP_BITS'(0);
            delay_out <= {NUM_LANES{TAP_BITS'(0)}};
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          cyc   <= CYC_W'(0);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cyc == SETTLE_LAST) begin
            cyc   <= CYC_W'(0);
            state <= MEASURE;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        MEASURE: begin
          if (cyc == DWELL_LAST) begin
            cyc   <= CYC_W'(0);
            state <= EVAL;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        EVAL: begin
          // done is raised on entry so it is high during the FINISH cycle.
          if (tap == TAP_MAX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            tap       <= tap_next;
            delay_out <= {NUM_LANES{tap_next}};
            state     <= LOAD;
          end
        end
        FINISH: begin
          for (int n = 0; n < NUM_LANES; n++) begin
            if (lane_found[n]) begin
              delay_out[n*TAP_BITS +: TAP_BITS] <= lane_centre[n];
              locked[n] <= 1'b1;
              fail[n]   <= 1'b0;
            end else begin
              delay_out[n*TAP_BITS +: TAP_BITS] <= DEFAULT_TAP;
              locked[n] <= 1'b0;
              fail[n]   <= 1'b1;
            end
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    csi_rx_tap_window #(
      .TAP_BITS     (TAP_BITS),
      .DWELL_CYCLES (DWELL_CYCLES),
      .HIT_MIN      (HIT_MIN)
    ) u_window (
      .byte_clock  (byte_clock),
      .reset       (reset),
      .sweep_clear (sweep_clear),
      .load        (load),
      .measure     (measure),
      .eval        (eval),
      .finish      (finish),
      .tap         (tap),
      .data        (deser_in[8*n +: 8]),
      .found       (lane_found[n]),
      .centre      (lane_centre[n])
    );
  end

endmodule

// File: tb/tb_csi_rx_dat_deskew.sv
// ---------------------------------------------------------------------------
// tb_csi_rx_dat_deskew
// Randomised bench for csi_rx_dat_deskew. Each sweep is given a per-lane,
// per-tap hit plan; the bench generates the byte streams, counts sync hits in
// the measurement windows itself, and derives the expected centre from the
// longest good run of taps.
// ---------------------------------------------------------------------------
module tb_csi_rx_dat_deskew;

  localparam int NL   = 2;
  localparam int TB   = 5;
  localparam int NT   = 32;
  localparam int SET  = 8;
  localparam int DW   = 64;
  localparam int HMIN = 4;
  localparam int DEF  = 3;
  localparam int TAPC = SET + DW + 2;
  localparam int LAT  = NT * TAPC + 1;

  logic                 byte_clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [8*NL-1:0]      deser_in;
  logic [TB*NL-1:0]     delay_out;
  logic                 busy;
  logic                 done;
  logic [NL-1:0]        locked;
  logic [NL-1:0]        fail;

  int checks   = 0;
  int failures = 0;

  int          tgt     [NL][NT];
  int          hit_cnt [NL][NT];
  int          slot_k  [NL];
  logic [7:0]  prev_sent [NL];
  int          kfix;
  logic [NL-1:0]    exp_locked;
  logic [NL-1:0]    exp_fail;
  logic [TB*NL-1:0] exp_delay;

  csi_rx_dat_deskew #(
    .NUM_LANES     (NL),
    .TAP_BITS      (TB),
    .DEFAULT_DELAY (DEF),
    .SETTLE_CYCLES (SET),
    .DWELL_CYCLES  (DW),
    .HIT_MIN       (HMIN)
  ) dut (
    .byte_clock (byte_clock),
    .reset      (reset),
    .start      (start),
    .deser_in   (deser_in),
    .delay_out  (delay_out),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .fail       (fail)
  );

  always #5 byte_clock = ~byte_clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sync byte found anywhere in the bit stream starting inside the older byte.
  function automatic bit model_hit(input logic [7:0] p, input logic [7:0] c);
    logic [15:0] w;
    w = {p, c};
    for (int k = 0; k < 8; k++) begin
      if (((w >> (8 - k)) & 16'h00FF) == 16'h00B8) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Random byte that does not form a sync byte with the byte before it.
  function automatic logic [7:0] filler(input logic [7:0] p);
    logic [7:0] cand;
    for (int i = 0; i < 100; i++) begin
      cand = 8'($urandom_range(0, 255));
      if (cand != 8'hB8 && !model_hit(p, cand)) return cand;
    end
    return 8'h00;
  endfunction

  // Bytes for cycle c of a sweep (c=1 is the first LOAD cycle).
  task automatic drive_cycle(input int c);
    logic [8*NL-1:0] bus;
    logic [15:0]     pair;
    logic [7:0]      b;
    int t, o, mi, s, r, k;
    bus = {(8*NL){1'b0}};
    for (int l = 0; l < NL; l++) begin
      b = 8'h00;
      if (c >= 1 && c <= NT * TAPC) begin
        t = (c - 1) / TAPC;
        o = (c - 1) % TAPC;
        if (o >= 1 + SET && o < 1 + SET + DW) begin
          mi = o - 1 - SET;
          s  = mi / 4;
          r  = mi % 4;
          if (tgt[l][t] > 0) begin
            if (s < tgt[l][t] && r == 0) begin
              k = (kfix >= 0) ? kfix : int'($urandom_range(0, 7));
              slot_k[l] = k;
              pair = 16'hB800 >> k;
              b = pair[15:8];
            end else if (s < tgt[l][t] && r == 1) begin
              pair = 16'hB800 >> slot_k[l];
              b = pair[7:0];
            end else begin
              b = 8'h00;
            end
          end else begin
            b = filler(prev_sent[l]);
          end
          if (model_hit(prev_sent[l], b) && hit_cnt[l][t] < DW) hit_cnt[l][t]++;
        end else if (tgt[l][t] == 0) begin
          b = filler(prev_sent[l]);
        end
      end
      prev_sent[l] = b;
      bus[8*l +: 8] = b;
    end
    deser_in = bus;
  endtask

  // Expected results: centre of the earliest longest run of good taps.
  task automatic expect_results();
    int best_len, best_start, len;
    for (int l = 0; l < NL; l++) begin
      best_len = 0;
      best_start = 0;
      for (int t = 0; t < NT; t++) begin
        if (hit_cnt[l][t] >= HMIN && (t == 0 || hit_cnt[l][t-1] < HMIN)) begin
          len = 0;
          while (t + len < NT && hit_cnt[l][t+len] >= HMIN) len++;
          if (len > best_len) begin
            best_len = len;
            best_start = t;
          end
        end
      end
      exp_locked[l] = (best_len > 0);
      exp_fail[l]   = (best_len == 0);
      exp_delay[l*TB +: TB] = (best_len > 0) ? TB'(best_start + (best_len - 1) / 2) : TB'(DEF);
    end
  endtask

  task automatic clear_plan();
    for (int l = 0; l < NL; l++)
      for (int t = 0; t < NT; t++) tgt[l][t] = 0;
  endtask

  task automatic set_run(input int l, input int lo, input int hi, input int n);
    for (int t = lo; t <= hi; t++) tgt[l][t] = (n > 0) ? n : int'($urandom_range(HMIN, 16));
  endtask

  task automatic random_lane(input int l);
    for (int t = 0; t < NT; t++)
      tgt[l][t] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 12));
  endtask

  // One sweep; reset_at>0 aborts it with a reset, extra_start_at re-pulses start.
  task automatic run_sweep(input string name, input int reset_at, input int extra_start_at);
    int done_cycle, done_count;
    logic [TB-1:0]    tv;
    logic [TB*NL-1:0] held_delay;
    for (int l = 0; l < NL; l++)
      for (int t = 0; t < NT; t++) hit_cnt[l][t] = 0;
    done_cycle = -1;
    done_count = 0;
    held_delay = exp_delay;
    @(posedge byte_clock); #1;
    start = 1'b1;
    drive_cycle(0);
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge byte_clock); #1;
      start = (c == extra_start_at);
      drive_cycle(c);
      if (reset_at > 0 && c == reset_at + 1) begin
        check_eq({name, "_rst_busy"}, busy, 1'b0);
        check_eq({name, "_rst_done"}, done, 1'b0);
        check_eq({name, "_rst_delay"}, delay_out, {NL{TB'(DEF)}});
        check_eq({name, "_rst_locked"}, locked, {NL{1'b0}});
        check_eq({name, "_rst_fail"}, fail, {NL{1'b0}});
        reset = 1'b0;
        exp_locked = {NL{1'b0}};
        exp_fail   = {NL{1'b0}};
        exp_delay  = {NL{TB'(DEF)}};
        return;
      end
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (c == 1) check_eq({name, "_busy_rise"}, busy, 1'b1);
      if (c == 600) begin
        check_eq({name, "_hold_locked"}, locked, exp_locked);
        check_eq({name, "_hold_fail"}, fail, exp_fail);
      end
      if (c <= NT * TAPC && (c - 1) % TAPC == 0) begin
        tv = TB'((c - 1) / TAPC);
        check_eq({name, "_sweep_tap"}, delay_out, {NL{tv}});
      end
      if (c == LAT - 1) check_eq({name, "_busy_last"}, busy, 1'b1);
      if (c == LAT) check_eq({name, "_busy_fall"}, busy, 1'b0);
      if (c == LAT + 1) check_eq({name, "_idle_after"}, busy, 1'b0);
      if (c == reset_at) reset = 1'b1;
    end
    check_eq({name, "_done_latency"}, done_cycle, LAT);
    check_eq({name, "_done_pulses"}, done_count, 1);
    expect_results();
    check_eq({name, "_delay"}, delay_out, exp_delay);
    check_eq({name, "_locked"}, locked, exp_locked);
    check_eq({name, "_fail"}, fail, exp_fail);
    if (held_delay == exp_delay) check_eq({name, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    deser_in = {(8*NL){1'b0}};
    kfix = -1;
    for (int l = 0; l < NL; l++) begin
      prev_sent[l] = 8'h00;
      slot_k[l] = 0;
    end
    exp_locked = {NL{1'b0}};
    exp_fail   = {NL{1'b0}};
    exp_delay  = {NL{TB'(DEF)}};
    repeat (3) @(posedge byte_clock);
    #1;
    check_eq("reset_delay", delay_out, {NL{TB'(DEF)}});
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_locked", locked, {NL{1'b0}});
    check_eq("reset_fail", fail, {NL{1'b0}});
    reset = 1'b0;
    repeat (2) @(posedge byte_clock);

    // Lane 0 good only at 10..17, random lane 1.
    clear_plan();
    set_run(0, 10, 17, 0);
    random_lane(1);
    run_sweep("s1", 0, 0);
    check_eq("s1_l0_centre13", delay_out[TB-1:0], 5'd13);
    check_eq("s1_l0_locked", locked[0], 1'b1);

    // Longer later run wins; equal runs keep the earliest. Start in FINISH ignored.
    clear_plan();
    set_run(0, 3, 5, 0);
    set_run(0, 20, 27, 0);
    set_run(1, 2, 5, 0);
    set_run(1, 12, 15, 0);
    run_sweep("s2", 0, LAT);
    check_eq("s2_l0_centre23", delay_out[TB-1:0], 5'd23);
    check_eq("s2_l1_centre3", delay_out[2*TB-1:TB], 5'd3);

    // Lane 0 good everywhere, lane 1 never good.
    clear_plan();
    set_run(0, 0, NT - 1, 0);
    run_sweep("s3", 0, 0);
    check_eq("s3_l0_centre15", delay_out[TB-1:0], 5'd15);
    check_eq("s3_l1_default", delay_out[2*TB-1:TB], 5'd3);
    check_eq("s3_l1_fail", fail[1], 1'b1);
    check_eq("s3_l1_locked", locked[1], 1'b0);

    // Run up to the top tap with split sync bytes; hit threshold on lane 1.
    clear_plan();
    kfix = 3;
    set_run(0, 26, 31, 5);
    set_run(1, 5, 9, HMIN - 1);
    set_run(1, 15, 18, HMIN);
    set_run(1, 19, 19, HMIN - 1);
    run_sweep("s4", 0, 0);
    check_eq("s4_l0_centre28", delay_out[TB-1:0], 5'd28);
    check_eq("s4_l1_centre16", delay_out[2*TB-1:TB], 5'd16);
    kfix = -1;

    // Random plans, start re-pulsed mid-sweep.
    clear_plan();
    random_lane(0);
    random_lane(1);
    run_sweep("s5", 0, 600);

    // Reset while tap 12 is being measured, then a fresh full sweep.
    clear_plan();
    random_lane(0);
    random_lane(1);
    run_sweep("s6", 1 + 12 * TAPC + 20, 0);
    repeat (2) @(posedge byte_clock);
    clear_plan();
    random_lane(0);
    random_lane(1);
    run_sweep("s7", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi_rx_dat_deskew.md
# csi_rx_dat_deskew

Per-lane IDELAY tap calibrator for the CSI-2 RX data lanes, running in the byte clock domain next to the data PHY instances. On `start` it sweeps one shared tap value over all lanes and counts HS sync-byte hits per lane at each tap. It then drives each lane's `delay` input with the centre of that lane's longest contiguous window of good taps. This replaces the fixed `DELAY` parameter and static `delay` wiring with run-time eye centring for 1–4 lanes.

## Interface

Parameters:
- `NUM_LANES`, 2: number of data lanes, 1..4.
- `TAP_BITS`, 5: delay tap width. Taps 0..2^TAP_BITS-1.
- `DEFAULT_DELAY`, 5'd3: tap driven after reset and on failed lanes.
- `SETTLE_CYCLES`, 8: cycles waited after a tap change before measuring. Minimum 1.
- `DWELL_CYCLES`, 64: measurement cycles per tap. Minimum 1.
- `HIT_MIN`, 4: minimum hit count for a tap to count as good. Range 1..DWELL_CYCLES.

Ports:
- Clock `byte_clock`; reset `reset`. One clock; `reset` is synchronous, active-high.
- `byte_clock`, in, 1: byte clock; every register is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle pulse that starts a sweep. Ignored while `busy`=1.
- `deser_in`, in, 8*NUM_LANES: deserialised bytes, lane n in [8n+7:8n]. Bit 7 is the earliest-received bit.
- `delay_out`, out, TAP_BITS*NUM_LANES: tap value to each lane's `delay` input.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `locked`, out, NUM_LANES: lane found at least one good tap in the last sweep.
- `fail`, out, NUM_LANES: lane found no good tap in the last sweep.

## Operation

- Hit detection, per lane, every cycle:
  - window = {prev_byte, cur_byte}, 16 bits.
  - hit = window[15-k -: 8] == SYNC_BYTE for any k in 0..7. Any bit alignment counts.
  - prev_byte is registered. It is cleared to 0 on reset and on each LOAD.
- FSM states:
  - IDLE: on `start`, set tap=0 and go to LOAD.
  - LOAD: 1 cycle. All lanes' `delay_out` = tap. Clear hit counters. Go to SETTLE.
  - SETTLE: SETTLE_CYCLES cycles, hits ignored. Go to MEASURE.
  - MEASURE: DWELL_CYCLES cycles. Hit counters increment on hit, saturating at DWELL_CYCLES, width $clog2(DWELL_CYCLES+1). Go to EVAL.
  - EVAL: 1 cycle. Each lane's window tracker is updated with good = (count >= HIT_MIN). If tap is the maximum, go to FINISH; otherwise tap+1 and go to LOAD.
  - FINISH: 1 cycle.
    - Close any open run.
    - Latch results, assert `done`, go to IDLE.
    - Per lane: if a window was found, `delay_out` = centre, `locked`=1, `fail`=0. Otherwise `delay_out` = DEFAULT_DELAY, `locked`=0, `fail`=1.
- Window tracker, per lane:
  - Tracks the current run start and length, and the best run start and length.
  - A run closes on a bad tap or in FINISH.
  - A closed run replaces the best only if strictly longer, so the earliest of equal-length runs wins.
  - centre = best_start + (best_len-1)/2, floor division, no wrap.
- Results from a sweep hold until the next sweep's FINISH. During a sweep, all lanes are driven with the sweep tap.
- Reset mid-sweep: return to IDLE; all outputs take their reset values.

## Timing

- Reset values: `delay_out` = DEFAULT_DELAY on all lanes; `busy`, `done`, `locked`, `fail` = 0. FSM in IDLE.
- `busy` rises the cycle after `start` is sampled. It falls in the same cycle that `done` pulses.
- Each tap takes SETTLE_CYCLES + DWELL_CYCLES + 2 cycles (LOAD + EVAL).
- Sweep latency, `start` to `done`: 2^TAP_BITS × (SETTLE_CYCLES+DWELL_CYCLES+2) + 1 cycles. With defaults: 32 × 74 + 1 = 2369.
- `delay_out` changes only on LOAD entry and in FINISH. It is registered, with no combinational path from any input.
- `start` in the same cycle as FINISH is ignored. `start` is accepted from the first IDLE cycle onward.

## Structure

- Add to `top_pkg`:
  - `DPHY_SYNC_BYTE` = 8'hB8.
  - `DPHY_TAP_BITS` = 5.
  - FSM state enum `deskew_state_t` (IDLE, LOAD, SETTLE, MEASURE, EVAL, FINISH).
- One sub-module, `csi_rx_tap_window`, instantiated once per lane. It contains the hit detector, hit counter, run/best tracker and centre computation.
- The top level holds the shared FSM, the cycle counter and the tap counter.

## Test plan

1. Lane 0 receives the sync byte only at taps 10..17; other taps receive random non-sync bytes. Required: `delay_out` lane 0 = 13, `locked`[0]=1, `done` exactly 2369 cycles after `start`.
2. Good runs at 3..5 and 20..27. Required: centre 23. Second check: equal runs 2..5 and 12..15 give 3, the earliest run.
3. No good tap on lane 1, lane 0 good at 0..31. Required: lane 1 `delay_out`=3, `fail`[1]=1, `locked`[1]=0. Lane 0 centre = 15.
4. Run touching the top, 26..31, closed only in FINISH. Required: centre 28. Sync byte split across a byte boundary at offset k=3 is counted as a hit.
5. Hit count threshold: exactly HIT_MIN-1 = 3 hits at a tap makes it bad; exactly 4 makes it good.
6. Protocol corners:
   - `start` re-pulsed mid-sweep: ignored, latency unchanged.
   - `reset` at tap 12: next cycle `busy`=0, `delay_out`=3, `locked`=0.
   - A new `start` after that runs a full sweep.
